fifo_pixel_reader: RTL and testbench

//  Downstream of the camera/FIFO interface: drives the AL422-style FIFO read side
//  (read clock, read-pointer reset, output enable) and consumes the byte stream.

---
 rtl/fifo_pixel_reader.sv | 197 +++++++++++++++++++
 tb/tb_fifo_pixel_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pixel_reader.sv
// Reads one frame from an AL422-style FIFO and pairs bytes into RGB565 pixels.
// It also drives the FIFO read clock, the read-pointer reset and output enable, and tags each pixel with x/y.
module fifo_pixel_reader #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CLK_DIV  = 2,
  parameter int RRST_PER = 2,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    din,
  output logic          fifo_rdclk,
  output logic          fifo_rrst,
  output logic          fifo_oe,
  output logic [15:0]   pixel,
  output logic          pixel_valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          busy,
  output logic          frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (RRST_PER > 1) ? $clog2(RRST_PER) : 1;

  typedef enum logic [1:0] {IDLE, RRST, READ, DONE} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   div, div_next;
  logic [RW-1:0]   fall_cnt, fall_cnt_next;
  logic [7:0]      hold, hold_next;
  logic            phase, phase_next;
  logic            rdclk_next, rrst_next, oe_next, valid_next, busy_next, done_next;
  logic [15:0]     pixel_next;
  logic [XW-1:0]   x_next;
  logic [YW-1:0]   y_next;
  logic            tick, fall, at_last;

  assign tick    = (div == DW'(CLK_DIV - 1));
  assign fall    = tick && fifo_rdclk;
  assign at_last = (x == XW'(H_ACTIVE - 1)) && (y == YW'(V_ACTIVE - 1));

  always_comb begin
    state_next    = state;
    div_next      = div;
    fall_cnt_next = fall_cnt;
    hold_next     = hold;
    phase_next    = phase;
    rdclk_next    = fifo_rdclk;
    rrst_next     = fifo_rrst;
    oe_next       = fifo_oe;
    pixel_next    = pixel;
    valid_next    = 1'b0;
    x_next        = x;
    y_next        = y;
    busy_next     = busy;
    done_next     = 1'b0;

    unique case (state)
      IDLE: begin
        div_next   = '0;
        rdclk_next = 1'b0;
        if (start && !abort) begin
          state_next    = RRST;
          rrst_next     = 1'b1;
          oe_next       = 1'b1;
          busy_next     = 1'b1;
          fall_cnt_next = '0;
          phase_next    = 1'b0;
        end
      end
      RRST: begin
        if (tick) begin
          div_next   = '0;
          rdclk_next = ~fifo_rdclk;
        end else begin
          div_next = div + DW'(1);
        end
        if (fall) begin
          if (fall_cnt == RW'(RRST_PER - 1)) begin
            state_next = READ;
            rrst_next  = 1'b0;
            oe_next    = 1'b0;
            div_next   = '0;
            rdclk_next = 1'b0;
            phase_next = 1'b0;
          end else begin
            fall_cnt_next = fall_cnt + RW'(1);
          end
        end
      end
      READ: begin
        // The read clock stays low while the final pixel is presented, so no extra FIFO byte is consumed.
        if (!(pixel_valid && at_last)) begin
          if (tick) begin
            div_next   = '0;
            rdclk_next = ~fifo_rdclk;
          end else begin
            div_next = div + DW'(1);
          end
        end
        if (fall) begin
          if (!phase) begin
            hold_next  = din;
            phase_next = 1'b1;
          end else begin
            pixel_next = {hold, din};
            valid_next = 1'b1;
            phase_next = 1'b0;
          end
        end
        if (pixel_valid) begin
          if (x == XW'(H_ACTIVE - 1)) begin
            x_next = '0;
            if (y == YW'(V_ACTIVE - 1)) begin
              y_next     = '0;
              state_next = DONE;
              done_next  = 1'b1;
              busy_next  = 1'b0;
              oe_next    = 1'b1;
              rdclk_next = 1'b0;
              div_next   = '0;
            end else begin
              y_next = y + YW'(1);
            end
          end else begin
            x_next = x + XW'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        oe_next    = 1'b1;
        rdclk_next = 1'b0;
        div_next   = '0;
      end
      default: state_next = IDLE;
    endcase

    // An abort discards any half-assembled pixel and returns every output to its idle value.
    if (abort && (state == RRST || state == READ)) begin
      state_next    = IDLE;
      div_next      = '0;
      fall_cnt_next = '0;
      phase_next    = 1'b0;
      rdclk_next    = 1'b0;
      rrst_next     = 1'b0;
      oe_next       = 1'b1;
      pixel_next    = '0;
      valid_next    = 1'b0;
      x_next        = '0;
      y_next        = '0;
      busy_next     = 1'b0;
      done_next     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      div         <= '0;
      fall_cnt    <= '0;
      hold        <= '0;
      phase       <= 1'b0;
      fifo_rdclk  <= 1'b0;
      fifo_rrst   <= 1'b0;
      fifo_oe     <= 1'b1;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      div         <= div_next;
      fall_cnt    <= fall_cnt_next;
      hold        <= hold_next;
      phase       <= phase_next;
      fifo_rdclk  <= rdclk_next;
      fifo_rrst   <= rrst_next;
      fifo_oe     <= oe_next;
      pixel       <= pixel_next;
      pixel_valid <= valid_next;
      x           <= x_next;
      y           <= y_next;
      busy        <= busy_next;
      frame_done  <= done_next;
    end
  end

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Scoreboard bench for fifo_pixel_reader on a 4x2 frame, with a byte-serving FIFO model.
module tb_fifo_pixel_reader;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          fifo_rdclk, fifo_rrst, fifo_oe, pixel_valid, busy, frame_done;
  logic [15:0]   pixel;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  fifo_pixel_reader #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CLK_DIV(1), .RRST_PER(2), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .din(din),
    .fifo_rdclk(fifo_rdclk), .fifo_rrst(fifo_rrst), .fifo_oe(fifo_oe),
    .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done;
    logic [15:0] pix;
    int          px;
    int          py;
    bit          gap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int dones = 0;
  int cyc = 0;
  int last_cyc = 0;
  int ptr = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FIFO model: pointer cleared by rrst, bytes 0x01.. presented after each rising read clock.
  always @(posedge fifo_rdclk) begin
    if (fifo_rrst) ptr = 0;
    else if (!fifo_oe) begin
      din = (ptr < 2*H*V) ? 8'(ptr + 1) : 8'hEE;
      ptr++;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (pixel_valid) begin
      strobes++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pixel actual=%0h required=none", pixel);
      end else begin
        e = q.pop_front();
        chk("event_kind_pixel", 0, int'(e.done));
        chk("pixel_value", int'(pixel), int'(e.pix));
        chk("pixel_x", int'(x), e.px);
        chk("pixel_y", int'(y), e.py);
        if (e.gap) chk("strobe_gap", cyc - last_cyc, 4);
      end
      last_cyc = cyc;
    end
    if (frame_done) begin
      dones++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("event_kind_done", 1, int'(e.done));
        chk("done_busy", int'(busy), 0);
        chk("done_oe", int'(fifo_oe), 1);
        chk("done_rdclk", int'(fifo_rdclk), 0);
        chk("done_xy", int'({x, y}), 0);
        chk("frame_bytes", ptr, 2*H*V);
      end
    end
  end

  task automatic push_frame(input int npix);
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      e.done = 1'b0;
      e.pix  = {8'(2*i + 1), 8'(2*i + 2)};
      e.px   = i % H;
      e.py   = i / H;
      e.gap  = (i != 0);
      q.push_back(e);
    end
    if (npix == H*V) begin
      e.done = 1'b1; e.pix = '0; e.px = 0; e.py = 0; e.gap = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdclk"}, int'(fifo_rdclk), 0);
    chk({tag, "_rrst"}, int'(fifo_rrst), 0);
    chk({tag, "_oe"}, int'(fifo_oe), 1);
    chk({tag, "_pixel"}, int'(pixel), 0);
    chk({tag, "_valid"}, int'(pixel_valid), 0);
    chk({tag, "_xy"}, int'({x, y}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(frame_done), 0);
  endtask

  task automatic start_frame();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rrst_high", int'(fifo_rrst), 1);
      chk("rrst_rdclk", int'(fifo_rdclk), i % 2);
      chk("rrst_oe", int'(fifo_oe), 1);
      chk("rrst_busy", int'(busy), 1);
    end
    @(negedge clk);
    chk("read_rrst", int'(fifo_rrst), 0);
    chk("read_oe", int'(fifo_oe), 0);
    chk("read_rdclk", int'(fifo_rdclk), 0);
  endtask

  task automatic wait_strobes(input int target, input string tag);
    int n;
    n = 0;
    while (strobes < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (strobes < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", tag, strobes, target);
    end
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (dones < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_frame_done_seen"}, dones, target);
  endtask

  initial begin
    int d0;
    int s0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #2 reset = 1'b1;

    // full frame
    push_frame(H*V);
    d0 = dones;
    start_frame();
    wait_done(d0 + 1, "frame1");
    @(negedge clk);
    chk("after_done_busy", int'(busy), 0);
    chk("after_done_oe", int'(fifo_oe), 1);
    chk("pixel_hold", int'(pixel), 16'h0F10);

    // abort after the third pixel
    push_frame(3);
    d0 = dones;
    s0 = strobes;
    start_frame();
    wait_strobes(s0 + 3, "abort");
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    @(negedge clk);
    check_idle("abort");
    repeat (20) @(posedge clk);
    chk("abort_no_frame_done", dones, d0);

    // fresh frame with start re-pulsed mid-read
    push_frame(H*V);
    d0 = dones;
    s0 = strobes;
    start_frame();
    wait_strobes(s0 + 2, "repulse");
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(d0 + 1, "frame3");

    // reset mid-read
    push_frame(2);
    s0 = strobes;
    start_frame();
    wait_strobes(s0 + 2, "midreset");
    #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    repeat (20) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
